lcd_readback: RTL and testbench

Read-side companion to the HD44780 16x2 LCD writer: executes LCD bus read cycles (RW=1) to fetch either the busy-flag/address-counter byte or a DDRAM/CGRAM data byte. The fetched byte is presented locally and forwarded to the UART transmitter, so the PC can read back display contents. It sits between the top-level LCD pins (RS/RW/E, with the 8-bit bus tristated at the top when RW=1) and the uart_top tx port.

---
 rtl/lcd_readback.sv | 242 ++++++++++++++++++++++++
 tb/tb_lcd_readback.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_readback.sv
// lcd_readback: runs HD44780 bus read cycles to fetch the busy-flag/address byte or a data byte.
// Optional macro LCD_RD_UART_EN compiles in the UART forwarding handshake (TX_REQ/TX_WAIT).
module lcd_readback #(
   parameter int SETUP_CYC   = 4,
   parameter int E_PULSE_CYC = 25,
   parameter int HOLD_CYC    = 4,
   parameter int BF_TIMEOUT  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_req,
   input  logic       rd_rs,
   input  logic [7:0] D_in,
   output logic       RS,
   output logic       RW,
   output logic       E,
   output logic       rd_busy,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       timeout,
   output logic [7:0] tx_parallel,
   output logic       tx_enable,
   input  logic       tx_ready
);

   localparam int MAX_SE  = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
   localparam int MAX_CYC = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int POLL_W  = $clog2(BF_TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]  E_LAST     = CNT_W'(E_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [POLL_W-1:0] POLL_MAX   = POLL_W'(BF_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      E_HIGH  = 3'd2,
      HOLD    = 3'd3,
      CHECK   = 3'd4,
      DONE    = 3'd5,
      TX_REQ  = 3'd6,
      TX_WAIT = 3'd7
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [POLL_W-1:0] poll_r, poll_s;
   logic              mode_r, mode_s;
   logic              data_cyc_r, data_cyc_s;
   logic [7:0]        capture_r, capture_s;
   logic [7:0]        rd_data_r, rd_data_s;
   logic              timeout_s;
   logic              bus_s;

   logic              rs_r, rw_r, e_r;
   logic              rd_busy_r, rd_valid_r, timeout_r;

`ifdef LCD_RD_UART_EN
   logic [7:0]        tx_par_r, tx_par_s;
   logic              tx_en_r;
`else
   logic              unused_tx_ready_s;
`endif

   // Next-state and next-value logic for the read sequencer
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r + 1'b1;
      poll_s     = poll_r;
      mode_s     = mode_r;
      data_cyc_s = data_cyc_r;
      capture_s  = capture_r;
      rd_data_s  = rd_data_r;
      timeout_s  = 1'b0;
`ifdef LCD_RD_UART_EN
      tx_par_s   = tx_par_r;
`endif
      case (state_r)
         IDLE: begin
            cnt_s = {CNT_W{1'b0}};
            if (rd_req) begin
               state_s    = SETUP;
               mode_s     = rd_rs;
               poll_s     = {POLL_W{1'b0}};
               data_cyc_s = 1'b0;
            end else begin
               state_s    = IDLE;
            end
         end
         SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               state_s = E_HIGH;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = SETUP;
            end
         end
         E_HIGH: begin
            // The bus byte is taken on the final E-high clock, when it is most settled.
            if (cnt_r == E_LAST) begin
               capture_s = D_in;
               state_s   = HOLD;
               cnt_s     = {CNT_W{1'b0}};
            end else begin
               state_s   = E_HIGH;
            end
         end
         HOLD: begin
            if (cnt_r == HOLD_LAST) begin
               state_s = CHECK;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = HOLD;
            end
         end
         CHECK: begin
            cnt_s = {CNT_W{1'b0}};
            if (!mode_r || data_cyc_r) begin
               rd_data_s = capture_r;
               state_s   = DONE;
`ifdef LCD_RD_UART_EN
               tx_par_s  = capture_r;
`endif
            end else if (capture_r[7]) begin
               // Controller busy: poll again unless the poll budget is spent.
               poll_s = (poll_r == POLL_MAX) ? poll_r : (poll_r + 1'b1);
               if (poll_s == POLL_MAX) begin
                  timeout_s = 1'b1;
                  state_s   = IDLE;
               end else begin
                  state_s   = SETUP;
               end
            end else begin
               data_cyc_s = 1'b1;
               state_s    = SETUP;
            end
         end
         DONE: begin
            cnt_s = {CNT_W{1'b0}};
`ifdef LCD_RD_UART_EN
            state_s = TX_REQ;
`else
            state_s = IDLE;
`endif
         end
`ifdef LCD_RD_UART_EN
         TX_REQ: begin
            cnt_s = {CNT_W{1'b0}};
            if (!tx_ready) begin
               state_s = TX_WAIT;
            end else begin
               state_s = TX_REQ;
            end
         end
         TX_WAIT: begin
            cnt_s = {CNT_W{1'b0}};
            if (tx_ready) begin
               state_s = IDLE;
            end else begin
               state_s = TX_WAIT;
            end
         end
`else
         TX_REQ, TX_WAIT: begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
         end
`endif
         default: begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
         end
      endcase
   end

   assign bus_s = (state_s == SETUP) || (state_s == E_HIGH) ||
                  (state_s == HOLD)  || (state_s == CHECK);

   // State and registered outputs; outputs follow the upcoming state so they align with it
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         poll_r     <= {POLL_W{1'b0}};
         mode_r     <= 1'b0;
         data_cyc_r <= 1'b0;
         capture_r  <= 8'h00;
         rd_data_r  <= 8'h00;
         rs_r       <= 1'b0;
         rw_r       <= 1'b0;
         e_r        <= 1'b0;
         rd_busy_r  <= 1'b0;
         rd_valid_r <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         poll_r     <= poll_s;
         mode_r     <= mode_s;
         data_cyc_r <= data_cyc_s;
         capture_r  <= capture_s;
         rd_data_r  <= rd_data_s;
         rs_r       <= bus_s && data_cyc_s;
         rw_r       <= bus_s;
         e_r        <= (state_s == E_HIGH);
         rd_busy_r  <= (state_s != IDLE);
         rd_valid_r <= (state_s == DONE);
         timeout_r  <= timeout_s;
      end
   end

`ifdef LCD_RD_UART_EN
   // UART request register and the byte handed to the transmitter
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_par_r <= 8'h00;
         tx_en_r  <= 1'b0;
      end else begin
         tx_par_r <= tx_par_s;
         tx_en_r  <= (state_s == TX_REQ);
      end
   end

   assign tx_parallel = tx_par_r;
   assign tx_enable   = tx_en_r;
`else
   assign tx_parallel       = 8'h00;
   assign tx_enable         = 1'b0;
   assign unused_tx_ready_s = tx_ready;
`endif

   assign RS       = rs_r;
   assign RW       = rw_r;
   assign E        = e_r;
   assign rd_busy  = rd_busy_r;
   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;
   assign timeout  = timeout_r;

endmodule

// File: tb/tb_lcd_readback.sv
// Directed self-checking bench for lcd_readback: default instance plus a BF_TIMEOUT=3 instance.
module tb_lcd_readback;

   logic       clk = 1'b0;
   logic       rst, rd_req, rd_rs, tx_ready;
   logic [7:0] d_in;
   logic       RS, RW, E, rd_busy, rd_valid, timeout, tx_enable;
   logic [7:0] rd_data, tx_parallel;

   logic       rd_req_b, rd_rs_b;
   logic [7:0] d_in_b;
   logic       RS_b, RW_b, E_b, rd_busy_b, rd_valid_b, timeout_b, tx_enable_b;
   logic [7:0] rd_data_b, tx_parallel_b;

   int checks = 0, failures = 0;
   int cyc, e_pulses, e_rs_pulses, e_high, e_first, rw_viol, valid_cnt, valid_cyc, to_cnt, tx_seen;
   int eb_pulses, vb_cnt, tob_cnt, tob_cyc, txb_seen;
   logic e_prev, rw_prev, eb_prev;

   lcd_readback dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_rs(rd_rs), .D_in(d_in),
      .RS(RS), .RW(RW), .E(E), .rd_busy(rd_busy), .rd_data(rd_data),
      .rd_valid(rd_valid), .timeout(timeout), .tx_parallel(tx_parallel),
      .tx_enable(tx_enable), .tx_ready(tx_ready)
   );

   lcd_readback #(.BF_TIMEOUT(3)) dut_b (
      .clk(clk), .rst(rst), .rd_req(rd_req_b), .rd_rs(rd_rs_b), .D_in(d_in_b),
      .RS(RS_b), .RW(RW_b), .E(E_b), .rd_busy(rd_busy_b), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .timeout(timeout_b), .tx_parallel(tx_parallel_b),
      .tx_enable(tx_enable_b), .tx_ready(1'b1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; e_pulses = 0; e_rs_pulses = 0; e_high = 0; e_first = 0; rw_viol = 0;
      valid_cnt = 0; valid_cyc = 0; to_cnt = 0; tx_seen = 0;
      eb_pulses = 0; vb_cnt = 0; tob_cnt = 0; tob_cyc = 0; txb_seen = 0;
      e_prev = E; rw_prev = RW; eb_prev = E_b;
   endtask

   // Advance one clock and observe both DUTs 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (E && !e_prev) begin
         e_pulses++;
         if (e_pulses == 1) e_first = cyc;
         if (RS) e_rs_pulses++;
      end
      if (E) e_high++;
      if ((E || e_prev) && (RW !== rw_prev)) rw_viol++;
      e_prev = E; rw_prev = RW;
      if (rd_valid) begin valid_cnt++; valid_cyc = cyc; end
      if (timeout) to_cnt++;
      if (tx_enable) tx_seen++;
      if (E_b && !eb_prev) eb_pulses++;
      eb_prev = E_b;
      if (rd_valid_b) vb_cnt++;
      if (timeout_b) begin tob_cnt++; tob_cyc = cyc; end
      if (tx_enable_b) txb_seen++;
   endtask

   task automatic finish_tx();
`ifdef LCD_RD_UART_EN
      tick();
      tx_ready = 1'b0; tick();
      tx_ready = 1'b1; tick();
`else
      tick();
`endif
   endtask

   initial begin
      rst = 1'b0; rd_req = 1'b0; rd_rs = 1'b0; d_in = 8'h00; tx_ready = 1'b1;
      rd_req_b = 1'b0; rd_rs_b = 1'b0; d_in_b = 8'h00;
      clear_stats();
      tick(); tick();
      chk("rst_RS", RS, 1'b0);
      chk("rst_RW", RW, 1'b0);
      chk("rst_E", E, 1'b0);
      chk("rst_busy", rd_busy, 1'b0);
      chk("rst_data", rd_data, 8'h00);
      chk("rst_valid", rd_valid, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_txpar", tx_parallel, 8'h00);
      chk("rst_txen", tx_enable, 1'b0);
      rst = 1'b1; tick();

      // Status read returning 0x25
      d_in = 8'h25; rd_rs = 1'b0; rd_req = 1'b1;
      clear_stats();
      tick();
      rd_req = 1'b0;
      chk("st_busy", rd_busy, 1'b1);
      chk("st_RW", RW, 1'b1);
      chk("st_RS", RS, 1'b0);
      chk("st_E_setup", E, 1'b0);
      for (int i = 0; i < 80 && valid_cnt == 0; i++) tick();
      chk("st_valid_seen", valid_cnt, 1);
      chk("st_valid_cyc", valid_cyc, 35);
      chk("st_e_first", e_first, 5);
      chk("st_e_high", e_high, 25);
      chk("st_e_pulses", e_pulses, 1);
      chk("st_rs_pulses", e_rs_pulses, 0);
      chk("st_rw_stable", rw_viol, 0);
      chk("st_data", rd_data, 8'h25);
`ifdef LCD_RD_UART_EN
      chk("st_txpar", tx_parallel, 8'h25);
      chk("st_txen_dn", tx_enable, 1'b0);
      tick();
      chk("hs_txen_rise", tx_enable, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      chk("hs_txen_held", tx_enable, 1'b1);
      chk("hs_busy_held", rd_busy, 1'b1);
      tx_ready = 1'b0; tick();
      chk("hs_txen_fall", tx_enable, 1'b0);
      chk("hs_busy_wait", rd_busy, 1'b1);
      tick(); tick();
      chk("hs_busy_wait2", rd_busy, 1'b1);
      tx_ready = 1'b1; tick();
      chk("hs_busy_drop", rd_busy, 1'b0);
`else
      chk("st_txpar", tx_parallel, 8'h00);
      tick();
      chk("st_busy_drop", rd_busy, 1'b0);
      chk("st_txen", tx_enable, 1'b0);
`endif
      chk("st_one_valid", valid_cnt, 1);

      // Data read: three busy polls, one clear poll, then the data cycle
      rd_rs = 1'b1; d_in = 8'h80; rd_req = 1'b1;
      clear_stats();
      tick();
      rd_req = 1'b0;
      for (int i = 0; i < 400 && valid_cnt == 0; i++) begin
         d_in = (e_pulses <= 3) ? 8'h80 : ((e_pulses == 4) ? 8'h00 : 8'h41);
         tick();
      end
      chk("dr_valid_seen", valid_cnt, 1);
      chk("dr_valid_cyc", valid_cyc, 171);
      chk("dr_e_pulses", e_pulses, 5);
      chk("dr_rs_pulses", e_rs_pulses, 1);
      chk("dr_e_high", e_high, 125);
      chk("dr_rw_stable", rw_viol, 0);
      chk("dr_data", rd_data, 8'h41);
      chk("dr_timeout", to_cnt, 0);
      finish_tx();
      chk("dr_busy_end", rd_busy, 1'b0);
      chk("dr_RS_idle", RS, 1'b0);

      // Timeout on the BF_TIMEOUT=3 instance
      d_in_b = 8'h80; rd_rs_b = 1'b1; rd_req_b = 1'b1;
      clear_stats();
      tick();
      rd_req_b = 1'b0;
      for (int i = 0; i < 200 && tob_cnt == 0; i++) tick();
      for (int i = 0; i < 40; i++) tick();
      chk("to_pulses", tob_cnt, 1);
      chk("to_cyc", tob_cyc, 103);
      chk("to_e_pulses", eb_pulses, 3);
      chk("to_no_valid", vb_cnt, 0);
      chk("to_no_tx", txb_seen, 0);
      chk("to_busy", rd_busy_b, 1'b0);

      // Reset while E is high, then a clean status read
      d_in = 8'h25; rd_rs = 1'b0; rd_req = 1'b1;
      clear_stats();
      tick();
      rd_req = 1'b0;
      for (int i = 0; i < 20 && E !== 1'b1; i++) tick();
      tick(); tick();
      chk("rs_E_before", E, 1'b1);
      rst = 1'b0; tick();
      chk("rs_E", E, 1'b0);
      chk("rs_RW", RW, 1'b0);
      chk("rs_busy", rd_busy, 1'b0);
      chk("rs_valid_none", valid_cnt, 0);
      rst = 1'b1; tick();
      d_in = 8'h5A; rd_req = 1'b1;
      clear_stats();
      tick();
      rd_req = 1'b0;
      for (int i = 0; i < 80 && valid_cnt == 0; i++) tick();
      chk("rs2_valid_cyc", valid_cyc, 35);
      chk("rs2_e_high", e_high, 25);
      chk("rs2_data", rd_data, 8'h5A);
      finish_tx();

      // rd_req repeated mid-transaction must be ignored
      d_in = 8'h33; rd_req = 1'b1;
      clear_stats();
      tick();
      rd_req = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rd_req = 1'b1; tick();
      rd_req = 1'b0;
      for (int i = 0; i < 80 && valid_cnt == 0; i++) tick();
      chk("ig_valid_cyc", valid_cyc, 35);
      finish_tx();
      for (int i = 0; i < 60; i++) tick();
      chk("ig_one_valid", valid_cnt, 1);
      chk("ig_e_pulses", e_pulses, 1);
      chk("ig_data", rd_data, 8'h33);
      chk("ig_busy", rd_busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
